imem_loader: RTL



---
 rtl/imem_loader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Serial instruction-memory loader. Accepts a byte stream over valid/ready,
// packs three bytes per 20-bit instruction word, and writes the words to
// consecutive addresses from 0. A trailing byte holds the XOR of every data
// byte. While a session runs, the CPU is held off.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INSN_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INSN_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              cksum_err
);

  // Encodings are kept at their legacy values.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_B0    = 3'd1,
    S_B1    = 3'd2,
    S_B2    = 3'd3,
    S_WRITE = 3'd4,
    S_CKSUM = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q,   len_d;
  logic [ADDR_W-1:0]   cnt_q,   cnt_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [INSN_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          ck_q,    ck_d;
  logic                err_q,   err_d;
  logic                xfer;

  // Ready is decoded from state only, so there is no path from rx_valid.
  always_comb begin
    rx_ready = (state_q == S_B0) || (state_q == S_B1) ||
               (state_q == S_B2) || (state_q == S_CKSUM);
    xfer     = rx_valid && rx_ready;
  end

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ck_d    = ck_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          addr_d  = '0;
          ck_d    = '0;
          err_d   = 1'b0;
          state_d = (len != '0) ? S_B0 : S_CKSUM;
        end
      end

      S_B0: begin
        if (xfer) begin
          wdata_d[7:0] = rx_data;
          ck_d         = ck_q ^ rx_data;
          state_d      = S_B1;
        end
      end

      S_B1: begin
        if (xfer) begin
          wdata_d[15:8] = rx_data;
          ck_d          = ck_q ^ rx_data;
          state_d       = S_B2;
        end
      end

      // Only the low nibble is instruction data. The whole byte still
      // enters the checksum.
      S_B2: begin
        if (xfer) begin
          wdata_d[19:16] = rx_data[3:0];
          ck_d           = ck_q ^ rx_data;
          state_d        = S_WRITE;
        end
      end

      // Address and counter advance as the write cycle ends. len never
      // exceeds 2^ADDR_W-1, so cnt_q+1 cannot overflow before it matches.
      S_WRITE: begin
        cnt_d   = cnt_q + ADDR_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        state_d = (cnt_d == len_q) ? S_CKSUM : S_B0;
      end

      S_CKSUM: begin
        if (xfer) begin
          if (rx_data != ck_q) begin
            err_d = 1'b1;
          end
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any session at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ck_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ck_q    <= ck_d;
      err_q   <= err_d;
    end
  end

  // Status and memory-side outputs come from registers or a state decode.
  always_comb begin
    imem_we    = (state_q == S_WRITE);
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
    busy       = (state_q != S_IDLE);
    cpu_hold   = busy;
    done       = (state_q == S_FIN);
    cksum_err  = err_q;
  end

endmodule
